// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding for the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result handshakes of the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/serial_adder_fa_bit.sv
// fa_bit: combinational single-bit full adder cell
module fa_bit (
  output logic sum,
  output logic carryout,
  input  logic x,
  input  logic y,
  input  logic carryin
);
  assign sum      = x ^ y ^ carryin;
  assign carryout = (x & y) | (carryin & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder driving one full-adder cell per clock
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s, c;
  fa_bit u_fa (
    .sum      (s),
    .carryout (c),
    .x        (a_q[0]),
    .y        (b_q[0]),
    .carryin  (carry_q)
  );
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: load on acceptance, shift one bit per RUN cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE && bus.in_valid) begin
      state_d = ST_RUN;
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      res_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      res_d   = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = c;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH - 1)) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_DONE && bus.out_ready) begin
      state_d = ST_IDLE;
    end
  end
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = bus.out_valid ? res_q : '0;
  assign bus.cout      = bus.out_valid & carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder (WIDTH 8 and 1)
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(1)) b1 ();
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [8:0] r, output int lat);
    b8.a = a; b8.b = b; b8.cin = c; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    tick();
    b8.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (b8.out_valid) lat = i;
    end
    r = {b8.cout, b8.sum};
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    tests++; if (b8.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", b8.in_ready); end
    tests++; if (b8.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", b8.out_valid); end
    tests++; if ({b8.cout, b8.sum} !== 9'h000) begin fails++; $display("FAIL reset_result got %h want 000", {b8.cout, b8.sum}); end
    tests++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", b8.busy); end
    tests++; if (b1.in_ready !== 1'b1 || b1.busy !== 1'b0) begin fails++; $display("FAIL reset_w1 got ready=%b busy=%b want 1 0", b1.in_ready, b1.busy); end
    rst_n = 1'b1;
    tick();
    tests++; if (b8.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", b8.in_ready); end
  endtask
  task automatic test_basic();
    int early = 0;
    b8.a = 8'h3A; b8.b = 8'h25; b8.cin = 1'b0; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    tick();
    b8.in_valid = 1'b0;
    tests++; if (b8.busy !== 1'b1 || b8.in_ready !== 1'b0) begin fails++; $display("FAIL basic_accept got busy=%b ready=%b want 1 0", b8.busy, b8.in_ready); end
    for (int i = 1; i < 8; i++) begin
      tick();
      if (b8.out_valid !== 1'b0 || b8.busy !== 1'b1) early++;
    end
    tests++; if (early != 0) begin fails++; $display("FAIL basic_latency got %0d bad run cycles want 0", early); end
    tick();
    tests++; if (b8.out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b want 1", b8.out_valid); end
    tests++; if ({b8.cout, b8.sum} !== 9'h05F) begin fails++; $display("FAIL basic_sum got %h want 05f", {b8.cout, b8.sum}); end
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    tests++; if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0 || b8.out_valid !== 1'b0) begin fails++; $display("FAIL basic_idle got ready=%b busy=%b valid=%b want 1 0 0", b8.in_ready, b8.busy, b8.out_valid); end
  endtask
  task automatic test_overflow();
    logic [8:0] r;
    int         lat;
    do_op(8'hFF, 8'h01, 1'b0, r, lat);
    tests++; if (r !== 9'h100 || lat != 8) begin fails++; $display("FAIL ovf_ff_01 got %h lat %0d want 100 lat 8", r, lat); end
    do_op(8'hFF, 8'hFF, 1'b1, r, lat);
    tests++; if (r !== 9'h1FF || lat != 8) begin fails++; $display("FAIL ovf_ff_ff_c got %h lat %0d want 1ff lat 8", r, lat); end
  endtask
  task automatic test_backpressure();
    int bad = 0;
    b8.a = 8'h12; b8.b = 8'h34; b8.cin = 1'b0; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    tick();
    b8.a = 8'h0F; b8.b = 8'hF0; b8.cin = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    tests++; if (b8.out_valid !== 1'b1 || {b8.cout, b8.sum} !== 9'h046) begin fails++; $display("FAIL bp_first got valid=%b %h want 1 046", b8.out_valid, {b8.cout, b8.sum}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0 || {b8.cout, b8.sum} !== 9'h046) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_stall got %0d unstable cycles want 0", bad); end
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    tests++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", b8.in_ready, b8.out_valid); end
    tick();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++; if (b8.out_valid !== 1'b1 || {b8.cout, b8.sum} !== 9'h100) begin fails++; $display("FAIL bp_second got valid=%b %h want 1 100", b8.out_valid, {b8.cout, b8.sum}); end
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
  endtask
  task automatic test_reset_mid_run();
    logic [8:0] r;
    int         lat;
    b8.a = 8'h55; b8.b = 8'hAA; b8.cin = 1'b0; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    tests++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.busy !== 1'b0) begin fails++; $display("FAIL midrun_reset got valid=%b ready=%b busy=%b want 0 1 0", b8.out_valid, b8.in_ready, b8.busy); end
    b8.in_valid = 1'b1;
    tick();
    tick();
    tests++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL midrun_in_reset_busy got %b want 0", b8.busy); end
    b8.in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (b8.out_valid) begin
        tests++; fails++; $display("FAIL midrun_stale got out_valid=1 want 0");
        break;
      end
    end
    do_op(8'h01, 8'h02, 1'b1, r, lat);
    tests++; if (r !== 9'h004 || lat != 8) begin fails++; $display("FAIL midrun_after got %h lat %0d want 004 lat 8", r, lat); end
  endtask
  task automatic test_width1();
    b1.a = 1'b1; b1.b = 1'b1; b1.cin = 1'b1; b1.in_valid = 1'b1; b1.out_ready = 1'b0;
    tick();
    b1.in_valid = 1'b0;
    tests++; if (b1.out_valid !== 1'b0 || b1.busy !== 1'b1) begin fails++; $display("FAIL w1_run got valid=%b busy=%b want 0 1", b1.out_valid, b1.busy); end
    tick();
    tests++; if (b1.out_valid !== 1'b1 || {b1.cout, b1.sum} !== 2'b11) begin fails++; $display("FAIL w1_result got valid=%b %b want 1 11", b1.out_valid, {b1.cout, b1.sum}); end
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
    tests++; if (b1.in_ready !== 1'b1) begin fails++; $display("FAIL w1_idle got %b want 1", b1.in_ready); end
  endtask
  task automatic test_back_to_back();
    logic [8:0] q[$];
    logic [8:0] cur, want, got_v;
    int         sent = 0, got = 0, cyc = 0;
    logic       acc, hs;
    b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
    cur = 9'(b8.a) + 9'(b8.b) + 9'(b8.cin);
    b8.in_valid = 1'b1;
    while (got < 1000 && cyc < 60000) begin
      b8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc   = b8.in_valid & b8.in_ready;
      hs    = b8.out_valid & b8.out_ready;
      got_v = {b8.cout, b8.sum};
      tick();
      cyc++;
      if (acc) begin
        q.push_back(cur);
        sent++;
        if (sent < 1000) begin
          b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
          cur = 9'(b8.a) + 9'(b8.b) + 9'(b8.cin);
        end else b8.in_valid = 1'b0;
      end
      if (hs) begin
        want = (q.size() > 0) ? q.pop_front() : 9'hxxx;
        got++;
        tests++; if (got_v !== want) begin fails++; $display("FAIL rand_result #%0d got %h want %h", got, got_v, want); end
      end
    end
    b8.out_ready = 1'b0;
    tests++; if (got != 1000 || sent != 1000 || q.size() != 0) begin fails++; $display("FAIL rand_count got sent=%0d recv=%0d pending=%0d want 1000 1000 0", sent, got, q.size()); end
  endtask
  initial begin
    rst_n = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0; b1.out_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_width1();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder sitting directly upstream of the single-bit full-adder cell and driving it with one operand bit pair per clock. It accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake. It feeds bits LSB-first through one full-adder cell, registers the carry between bits, and assembles the sum in a shift register. It presents the WIDTH-bit sum and final carry over a second valid/ready handshake, trading latency for a one-cell adder datapath.

## Interface
- WIDTH, 8: operand and sum width in bits, ≥1.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: load a_sh←a, b_sh←b, carry←cin, cnt←0, res←0; go to RUN.
- **RUN**, once per cycle:
  - The cell computes s,c from a_sh[0], b_sh[0] and carry.
  - res←{s, res[WIDTH-1:1]}, carry←c, a_sh and b_sh shift right by 1, cnt←cnt+1.
  - When the bit being processed has cnt==WIDTH-1, go to DONE.
- **DONE**
  - out_valid=1, sum=res, cout=carry.
  - On out_ready, go to IDLE.
- Arithmetic: {cout,sum} equals a+b+cin exactly. No truncation other than the WIDTH-bit sum; overflow is reported only through cout.
- cnt width is $clog2(WIDTH+1). WIDTH=1 must work and spends exactly one cycle in RUN.
- in_ready=(state==IDLE). in_valid is ignored in RUN and DONE. Operands are captured only at acceptance, so later changes on a/b/cin have no effect.
- out_ready outside DONE is ignored. sum and cout stay stable for the whole time out_valid is high.
- **Reset:**
  - rst_n low at any time forces IDLE, clears a_sh, b_sh, res, carry and cnt, and aborts any operation in flight.
  - A result that was mid-RUN is never presented.
  - Reset values of the outputs: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
  - Inputs are ignored while rst_n is low.

## Timing
- Acceptance edge is T. RUN covers edges T+1 … T+WIDTH. out_valid rises after edge T+WIDTH, so latency is WIDTH cycles from acceptance to out_valid.
- The result handshake completes at the first edge with out_valid&&out_ready. IDLE is entered on that edge, and in_ready is high in the following cycle.
- Minimum initiation interval is WIDTH+2 cycles with out_ready held high.
- in_valid and out_ready are sampled only on rising clk edges. Outputs are registered or decoded from state only; there are no combinational input-to-output paths.

## Structure
- Package serial_adder_pkg holds the state encodings ST_IDLE=2'd0, ST_RUN=2'd1 and ST_DONE=2'd2.
- One sub-module, fa_bit (sum, carryout, x, y, carryin), is a purely combinational 1-bit full adder instantiated once. All sequential logic lives in serial_adder.

## Test plan
- WIDTH=8, a=0x3A, b=0x25, cin=0 accepted at edge T → out_valid at T+8, sum=0x5F, cout=0; busy high from T to the result handshake.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and keep in_valid high with new operands → sum/cout stay stable, in_ready=0, the second operand pair is not taken. Raising out_ready → IDLE next cycle, then the second pair is accepted.
- Reset mid-RUN: assert rst_n=0 after 3 bits of a=0x55+b=0xAA → out_valid=0, in_ready=1, busy=0 immediately. After release, a=0x01, b=0x02, cin=1 → sum=0x04, cout=0.
- WIDTH=1 build: a=1, b=1, cin=1 → out_valid one cycle after acceptance, sum=1, cout=1.
- 1000 random back-to-back operand sets with random out_ready stalls → every {cout,sum} equals a+b+cin, and one result is produced per accepted input, in order.
